dphy_rx_word_aligner: RTL

HS receive word aligner for a single D-PHY data lane, the receive-side counterpart of the lane serializer. It consumes raw 8-bit words from an upstream deserializer on the word clock, hunts for the HS sync byte at any of the 8 bit offsets, locks the offset, and emits byte-aligned payload with start/end-of-transmission strobes to the DSI packet layer. Bit ordering matches the transmit path: `d_i[0]` is the first bit on the wire.

---
 rtl/dphy_rx_word_aligner.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dphy_rx_word_aligner.sv
// HS receive word aligner for one D-PHY data lane: hunts for the sync byte at any
// of 8 bit offsets, locks that offset, and streams byte-aligned payload with SoT/EoT.
module dphy_rx_word_aligner #(
    parameter logic [7:0]  g_sync_byte    = 8'hB8,
    parameter int unsigned g_sync_timeout = 32
) (
    input  logic       clk_word_i,
    input  logic       rst_n_a_i,
    input  logic       hs_active_i,
    input  logic [7:0] d_i,
    output logic [7:0] q_o,
    output logic       q_valid_o,
    output logic       sot_o,
    output logic       eot_o,
    output logic       sync_err_o,
    output logic       locked_o,
    output logic [2:0] align_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(g_sync_timeout - 1);

    state_t      state_r;
    logic [7:0]  d_r;
    logic [7:0]  d_rr;
    logic [7:0]  cnt_r;
    logic [7:0]  q_r;
    logic [2:0]  align_r;
    logic        q_valid_r;
    logic        sot_r;
    logic        eot_r;
    logic        sync_err_r;
    logic        locked_r;
    logic        first_r;

    logic [15:0] win_s;
    logic        match_s;
    logic [2:0]  match_k_s;
    logic [7:0]  byte_s;

    // Input word pipeline forming the 16-bit search window (older word low)
    always_ff @(posedge clk_word_i or negedge rst_n_a_i) begin
        if (!rst_n_a_i) begin
            d_r  <= 8'h00;
            d_rr <= 8'h00;
        end else begin
            d_r  <= d_i;
            d_rr <= d_r;
        end
    end

    assign win_s  = {d_r, d_rr};
    assign byte_s = win_s[align_r +: 8];

    // Sync search over all offsets; descending scan so the lowest offset wins
    always_comb begin
        match_s   = 1'b0;
        match_k_s = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (win_s[k +: 8] == g_sync_byte) begin
                match_s   = 1'b1;
                match_k_s = 3'(k);
            end else begin
                match_s   = match_s;
                match_k_s = match_k_s;
            end
        end
    end

    // Alignment FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clk_word_i or negedge rst_n_a_i) begin
        if (!rst_n_a_i) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'h00;
            q_r        <= 8'h00;
            align_r    <= 3'd0;
            q_valid_r  <= 1'b0;
            sot_r      <= 1'b0;
            eot_r      <= 1'b0;
            sync_err_r <= 1'b0;
            locked_r   <= 1'b0;
            first_r    <= 1'b0;
        end else begin
            q_valid_r  <= 1'b0;
            sot_r      <= 1'b0;
            eot_r      <= 1'b0;
            sync_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    locked_r <= 1'b0;
                    if (hs_active_i) begin
                        state_r <= ST_HUNT;
                        cnt_r   <= 8'h00;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HUNT: begin
                    if (!hs_active_i) begin
                        state_r <= ST_IDLE;
                    end else if (match_s) begin
                        state_r  <= ST_LOCKED;
                        align_r  <= match_k_s;
                        locked_r <= 1'b1;
                        first_r  <= 1'b1;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        state_r    <= ST_ERROR;
                        sync_err_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    // Trailing bytes still in the pipeline are dropped on exit
                    if (!hs_active_i) begin
                        state_r  <= ST_IDLE;
                        locked_r <= 1'b0;
                        eot_r    <= 1'b1;
                    end else begin
                        q_r       <= byte_s;
                        q_valid_r <= 1'b1;
                        sot_r     <= first_r;
                        first_r   <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    if (!hs_active_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ERROR;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    assign q_o        = q_r;
    assign q_valid_o  = q_valid_r;
    assign sot_o      = sot_r;
    assign eot_o      = eot_r;
    assign sync_err_o = sync_err_r;
    assign locked_o   = locked_r;
    assign align_o    = align_r;

endmodule
